// File: rtl/imm_extend_arbiter.sv
// ---------------------------------------------------------------------------
// imm_extend_arbiter
//
// Shared immediate-extension unit. Two requesters (0 = decode, 1 = branch
// target logic) present IMM_W-bit immediates with a 2-bit extension mode.
// A round-robin arbiter grants at most one request per cycle. The granted
// immediate is extended to OUT_W bits and captured in a one-entry output
// slot, which is drained through a valid/ready handshake and tagged with
// the requester id.
//
// Extension modes (s = imm[IMM_W-1]):
//   00 sign   : {s..s, imm}
//   01 zero   : {0..0, imm}
//   10 upper  : {imm, 0..0}
//   11 branch : sign-extended immediate shifted left by 2
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req0_valid/ready       requester 0 handshake (ready = granted+accepted)
//   req0_imm, req0_mode    requester 0 immediate and extension mode
//   req1_valid/ready       requester 1 handshake
//   req1_imm, req1_mode    requester 1 immediate and extension mode
//   rsp_valid/ready        result slot handshake
//   rsp_id                 requester that owns rsp_data
//   rsp_data               extended result
//   grant0_cnt, grant1_cnt saturating per-requester accept counters
//                          (present only when IMMX_STATS_EN is defined)
//
// Optional feature macro: IMMX_STATS_EN
//
// Parameters:
//   IMM_W  immediate width
//   OUT_W  result width, expected to be 2*IMM_W
//   CNT_W  width of the grant counters (IMMX_STATS_EN only)
// ---------------------------------------------------------------------------
module imm_extend_arbiter #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [IMM_W-1:0] req0_imm,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [IMM_W-1:0] req1_imm,
    input  logic [1:0]       req1_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [OUT_W-1:0] rsp_data
`ifdef IMMX_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Extend one immediate according to its mode.
    function automatic logic [OUT_W-1:0] extend_imm(
        input logic [IMM_W-1:0] imm,
        input logic [1:0]       mode
    );
        logic signed [OUT_W-1:0] sext;
        logic        [OUT_W-1:0] res;
        sext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};
        case (mode)
            2'b00:   res = sext;
            2'b01:   res = {{(OUT_W-IMM_W){1'b0}}, imm};
            2'b10:   res = {imm, {(OUT_W-IMM_W){1'b0}}};
            default: res = sext <<< 2;
        endcase
        return res;
    endfunction

    slot_state_t      state;
    slot_state_t      state_next;
    logic             last_grant;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept0;
    logic             accept1;
    logic             accept;
    logic [IMM_W-1:0] sel_imm_p0;
    logic [1:0]       sel_mode_p0;
    logic [OUT_W-1:0] ext_data_p0;
    logic             vld_p0;
    logic [OUT_W-1:0] slot_data_p1;
    logic             slot_id_p1;

    // ---------------- stage p0: arbitration, grant, extension ----------------
    always_comb begin
        state_next = state;
        can_accept = (state == EMPTY) || rsp_ready;

        // Round robin: a lone requester always wins; under contention the
        // requester that was not granted last time wins.
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);

        // Readies are held low for the whole time reset is asserted.
        req0_ready = reset_n && can_accept && grant0;
        req1_ready = reset_n && can_accept && grant1;

        accept0 = req0_valid && req0_ready;
        accept1 = req1_valid && req1_ready;
        accept  = accept0 || accept1;

        // An accept refills the slot even while it drains, so the slot
        // stays FULL and throughput is one result per cycle.
        if (accept) begin
            state_next = FULL;
        end else if ((state == FULL) && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    assign vld_p0      = accept;
    assign sel_imm_p0  = accept1 ? req1_imm  : req0_imm;
    assign sel_mode_p0 = accept1 ? req1_mode : req0_mode;
    assign ext_data_p0 = extend_imm(sel_imm_p0, sel_mode_p0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            if (vld_p0) begin
                last_grant <= accept1;
            end
        end
    end

    // ---------------- stage p1: registered result slot ----------------
    // Data is cleared on reset as well so the slot reads zero afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_data_p1 <= '0;
            slot_id_p1   <= 1'b0;
        end else if (vld_p0) begin
            slot_data_p1 <= ext_data_p0;
            slot_id_p1   <= accept1;
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_id    = slot_id_p1;
    assign rsp_data  = slot_data_p1;

`ifdef IMMX_STATS_EN
    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (accept0) begin
                grant0_cnt <= sat_inc(grant0_cnt);
            end
            if (accept1) begin
                grant1_cnt <= sat_inc(grant1_cnt);
            end
        end
    end
`else
    // CNT_W only sizes the optional counters; nothing to build here.
    if (CNT_W > 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_imm_extend_arbiter.sv
module tb_imm_extend_arbiter;

`ifdef IMMX_STATS_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_imm;
    logic [1:0]  req0_mode;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_imm;
    logic [1:0]  req1_mode;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
`ifdef IMMX_STATS_EN
    logic [TB_CNT_W-1:0] grant0_cnt, grant1_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    imm_extend_arbiter #(.IMM_W(16), .OUT_W(32), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef IMMX_STATS_EN
        ,
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference extension from the arithmetic meaning of each mode.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        int sv;
        sv = int'($signed(imm));
        case (mode)
            2'd0:    return 32'(sv);
            2'd1:    return 32'(imm);
            2'd2:    return 32'(imm) * 32'd65536;
            default: return 32'(sv * 4);
        endcase
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_imm = '0; req0_mode = '0;
        req1_valid = 1'b0; req1_imm = '0; req1_mode = '0;
        rsp_ready  = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_readies got=%b want=00", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_data} !== 34'd0) begin
            n_bad++; $display("FAIL reset_outputs got=%b/%b/%h want=0/0/0", rsp_valid, rsp_id, rsp_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_imm = 16'hFFE2; req0_mode = 2'b00; rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL single_ready got=%b want=1", req0_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'hFFFFFFE2}) begin
            n_bad++; $display("FAIL single_rsp got=%b/%b/%h want=1/0/ffffffe2", rsp_valid, rsp_id, rsp_data);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({rsp_valid, rsp_data} !== {1'b0, 32'hFFFFFFE2}) begin
            n_bad++; $display("FAIL single_drain got=%b/%h want=0/ffffffe2", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_modes();
        logic [15:0] imms [4];
        logic [1:0]  modes [4];
        logic [31:0] exps [4];
        imms  = '{16'hFFE2, 16'h1234, 16'hFFFF, 16'h0028};
        modes = '{2'b01, 2'b10, 2'b11, 2'b11};
        exps  = '{32'h0000FFE2, 32'h12340000, 32'hFFFFFFFC, 32'h000000A0};
        idle_inputs();
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1'b1; req1_imm = imms[i]; req1_mode = modes[i];
            @(negedge clk);
            n_vec++;
            if (req1_ready !== 1'b1) begin
                n_bad++; $display("FAIL modes_ready[%0d] got=%b want=1", i, req1_ready);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, exps[i]}) begin
                n_bad++; $display("FAIL modes_rsp[%0d] got=%b/%b/%h want=1/1/%h", i, rsp_valid, rsp_id, rsp_data, exps[i]);
            end
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_contention();
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_imm = 16'h0001; req0_mode = 2'b01;
        req1_valid = 1'b1; req1_imm = 16'h0002; req1_mode = 2'b01;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL contention_grant[%0d] got r1r0=%b%b want winner=%0d", i, req1_ready, req0_ready, i % 2);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if ({rsp_id, rsp_data} !== {1'(i % 2), 32'(i % 2 + 1)}) begin
                n_bad++; $display("FAIL contention_rsp[%0d] got=%b/%h want=%0d/%0d", i, rsp_id, rsp_data, i % 2, i % 2 + 1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_imm = 16'h0028; req0_mode = 2'b00; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req0_imm = 16'h0005; req0_mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, rsp_data, req0_ready, req1_ready} !== {1'b1, 32'h00000028, 2'b00}) begin
                n_bad++; $display("FAIL stall[%0d] got v=%b d=%h r0=%b r1=%b want 1/00000028/0/0", i, rsp_valid, rsp_data, req0_ready, req1_ready);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL stall_release_ready got=%b want=1", req0_ready);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'h00000005}) begin
            n_bad++; $display("FAIL stall_release_rsp got=%b/%h want=1/00000005", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        do_reset();
        // req0 wins first, so without reset the next contended grant would be req1.
        req0_valid = 1'b1; req0_imm = 16'h0028; req0_mode = 2'b00; rsp_ready = 1'b0;
        @(posedge clk);
        #1 req1_valid = 1'b1; req1_imm = 16'h0077; req1_mode = 2'b01;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
            n_bad++; $display("FAIL async_reset got v=%b r0=%b r1=%b want 0/0/0", rsp_valid, req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_bad++; $display("FAIL async_reset_prio got r1r0=%b%b want 01", req1_ready, req0_ready);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'h00000028}) begin
            n_bad++; $display("FAIL async_reset_rsp got=%b/%b/%h want=1/0/00000028", rsp_valid, rsp_id, rsp_data);
        end
        idle_inputs();
    endtask

    // Random traffic against a transaction-level model of the slot.
    task automatic test_random();
        bit          m_full = 1'b0;
        bit          m_last = 1'b1;
        bit          m_id = 1'b0;
        logic [31:0] m_data = '0;
        bit          hold0 = 1'b0, hold1 = 1'b0;
        bit          can, e0, e1;
        idle_inputs();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold0) begin
                req0_valid = ($urandom % 3) != 0;
                req0_imm   = 16'($urandom);
                req0_mode  = 2'($urandom);
            end
            if (!hold1) begin
                req1_valid = ($urandom % 3) != 0;
                req1_imm   = 16'($urandom);
                req1_mode  = 2'($urandom);
            end
            rsp_ready = ($urandom % 4) != 0;
            @(negedge clk);
            can = !m_full || rsp_ready;
            e0 = 1'b0; e1 = 1'b0;
            if (can && req0_valid && req1_valid) begin
                if (m_last) e0 = 1'b1; else e1 = 1'b1;
            end else if (can) begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
            n_vec++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                n_bad++; $display("FAIL rand_ready[%0d] got r0r1=%b%b want %b%b", cyc, req0_ready, req1_ready, e0, e1);
            end
            n_vec++;
            if ({rsp_valid, rsp_id, rsp_data} !== {m_full, m_id, m_data}) begin
                n_bad++; $display("FAIL rand_rsp[%0d] got=%b/%b/%h want=%b/%b/%h", cyc, rsp_valid, rsp_id, rsp_data, m_full, m_id, m_data);
            end
            @(posedge clk);
            if (e0 || e1) begin
                m_full = 1'b1;
                m_id   = e1;
                m_data = e1 ? ref_ext(req1_imm, req1_mode) : ref_ext(req0_imm, req0_mode);
                m_last = e1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
            hold0 = req0_valid && !e0;
            hold1 = req1_valid && !e1;
            #1;
        end
        idle_inputs();
    endtask

`ifdef IMMX_STATS_EN
    task automatic test_stats();
        idle_inputs();
        do_reset();
        n_vec++;
        if ({grant0_cnt, grant1_cnt} !== '0) begin
            n_bad++; $display("FAIL stats_reset got=%0d/%0d want=0/0", grant0_cnt, grant1_cnt);
        end
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_imm = 16'h0003; req1_mode = 2'b00;
        repeat (5) @(posedge clk);
        #1 req1_valid = 1'b0;
        n_vec++;
        if ({grant0_cnt, grant1_cnt} !== {2'd0, 2'd3}) begin
            n_bad++; $display("FAIL stats_sat got g0=%0d g1=%0d want 0/3", grant0_cnt, grant1_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_modes();
        test_contention();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef IMMX_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
